// File: rtl/shared_resource_rr_n.sv
// N-channel round-robin front end for the shared combinational resource.
// Per-channel FIFO with empty bypass, registered output slot, and occupancy.

module shared_resource #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);
    assign result = operand * DATA_W'(3) + DATA_W'(1);
endmodule

module shared_resource_rr_n #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_flush,
    input  logic [NUM_CH-1:0]        in_stall,
    output logic [NUM_CH-1:0]        out_stall,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_flush,
    output logic [NUM_CH*CNT_W-1:0]  occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CH_W  = $clog2(NUM_CH);

    logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [CNT_W-1:0]  count  [NUM_CH];
    logic [DATA_W-1:0] operand [NUM_CH];

    logic [NUM_CH-1:0] empty, full, slot_free, req, grant, deq, enq;
    logic [CH_W-1:0]   rr, gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] res_in, res_out;

    // Per-channel status, request and operand selection (head or bypass)
    always_comb begin
        empty     = '0;
        full      = '0;
        slot_free = '0;
        req       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i]     = (count[i] == '0);
            full[i]      = (count[i] == CNT_W'(DEPTH));
            slot_free[i] = !out_valid[i] || !in_stall[i];
            req[i]       = (in_valid[i] || !empty[i]) && slot_free[i] && !in_flush[i];
            operand[i]   = empty[i] ? in_data[i*DATA_W +: DATA_W] : mem[i][rd_ptr[i]];
        end
    end

    // Round-robin scan starting at rr; first requester wins
    always_comb begin
        int unsigned idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(rr) + k) % NUM_CH;
            if (!gnt_any && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = CH_W'(idx);
                gnt_any    = 1'b1;
            end
        end
    end

    always_comb begin
        deq = '0;
        enq = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            deq[i] = grant[i] && !empty[i];
            enq[i] = in_valid[i] && !full[i] && !in_flush[i] && !(grant[i] && empty[i]);
        end
        res_in = operand[gnt_idx];
    end

    shared_resource #(.DATA_W(DATA_W)) u_resource (
        .operand (res_in),
        .result  (res_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr <= '0;
        end else if (gnt_any) begin
            rr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
    end

    // FIFO pointers/counts and the registered output slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            out_valid <= '0;
            out_flush <= '0;
            out_data  <= '0;
        end else begin
            out_flush <= in_flush;
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_flush[i]) begin
                    wr_ptr[i]    <= '0;
                    rd_ptr[i]    <= '0;
                    count[i]     <= '0;
                    out_valid[i] <= 1'b0;
                end else begin
                    if (enq[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                    if (deq[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    count[i] <= count[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
                    if (grant[i]) begin
                        out_valid[i]                  <= 1'b1;
                        out_data[i*DATA_W +: DATA_W]  <= res_out;
                    end else begin
                        out_valid[i] <= out_valid[i] && in_stall[i];
                    end
                end
            end
        end
    end

    // Storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (enq[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            occupancy[i*CNT_W +: CNT_W] = count[i];
        end
    end

    assign out_stall = full;

endmodule

// File: tb/tb_shared_resource_rr_n.sv
// Randomized bench for shared_resource_rr_n against a queue-based reference model.

module tb_shared_resource_rr_n;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid, in_flush, in_stall;
    logic [NUM_CH-1:0]        out_stall, out_valid, out_flush;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH*CNT_W-1:0]  occupancy;

    shared_resource_rr_n #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_flush  (in_flush),
        .in_stall  (in_stall),
        .out_stall (out_stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_flush (out_flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    logic [31:0] q [NUM_CH][$];
    bit          m_ov  [NUM_CH];
    logic [31:0] m_od  [NUM_CH];
    bit          m_of  [NUM_CH];
    bit          m_acc [NUM_CH];
    int          m_rr;

    bit          src_v [NUM_CH];
    logic [31:0] src_d [NUM_CH];

    function automatic logic [31:0] res(input logic [31:0] x);
        return x * 32'd3 + 32'd1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            q[i].delete();
            m_ov[i]  = 1'b0;
            m_od[i]  = '0;
            m_of[i]  = 1'b0;
            m_acc[i] = 1'b0;
        end
        m_rr = 0;
    endfunction

    function automatic void model_step();
        bit r [NUM_CH];
        int g;
        bit emp, ful;
        logic [31:0] d, op;
        g = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            emp  = (q[i].size() == 0);
            r[i] = (in_valid[i] || !emp) && (!m_ov[i] || !in_stall[i]) && !in_flush[i];
        end
        for (int k = 0; k < NUM_CH; k++)
            if (g < 0 && r[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            emp      = (q[i].size() == 0);
            ful      = (q[i].size() == DEPTH);
            d        = in_data[i*DATA_W +: DATA_W];
            m_acc[i] = 1'b0;
            m_of[i]  = in_flush[i];
            if (in_flush[i]) begin
                q[i].delete();
                m_ov[i] = 1'b0;
            end else begin
                if (g == i) begin
                    op      = emp ? d : q[i][0];
                    m_od[i] = res(op);
                    m_ov[i] = 1'b1;
                    if (!emp) void'(q[i].pop_front());
                    else m_acc[i] = 1'b1;
                end else begin
                    m_ov[i] = m_ov[i] && in_stall[i];
                end
                if (in_valid[i] && !ful && !(g == i && emp)) begin
                    q[i].push_back(d);
                    m_acc[i] = 1'b1;
                end
            end
        end
        if (g >= 0) m_rr = (g + 1) % NUM_CH;
    endfunction

    function automatic void chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d actual=%0h expected=%0h at %0t", name, ch, act, exp, $time);
        end
    endfunction

    function automatic void compare();
        for (int i = 0; i < NUM_CH; i++) begin
            chk("out_valid", i, 64'(out_valid[i]), 64'(m_ov[i]));
            chk("out_data", i, 64'(out_data[i*DATA_W +: DATA_W]), 64'(m_od[i]));
            chk("out_flush", i, 64'(out_flush[i]), 64'(m_of[i]));
            chk("occupancy", i, 64'(occupancy[i*CNT_W +: CNT_W]), 64'(q[i].size()));
            chk("out_stall", i, 64'(out_stall[i]), 64'(q[i].size() == DEPTH));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clk = 1'b0;
        reset = 1'b0;
        in_data = '0;
        in_valid = '0;
        in_flush = '0;
        in_stall = '0;
        model_reset();
        #3;
        compare();
        chk("reset_valid_lit", 0, 64'(out_valid), 64'd0);
        #9 reset = 1'b1;
        tick();

        // Single bypass on channel 0
        in_valid[0] = 1'b1;
        in_data[0*DATA_W +: DATA_W] = 32'h0000_0005;
        tick();
        chk("bypass_valid_lit", 0, 64'(out_valid[0]), 64'd1);
        chk("bypass_data_lit", 0, 64'(out_data[31:0]), 64'd16);
        chk("bypass_occ_lit", 0, 64'(occupancy[2:0]), 64'd0);
        in_valid = '0;
        tick();

        // Channel 1 stalled while upstream keeps sending
        in_valid[1] = 1'b1;
        in_data[1*DATA_W +: DATA_W] = 32'd100;
        tick();
        in_stall[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data[1*DATA_W +: DATA_W] = 32'(101 + c);
            tick();
        end
        chk("stall_occ_lit", 1, 64'(occupancy[5:3]), 64'd4);
        chk("stall_full_lit", 1, 64'(out_stall[1]), 64'd1);
        chk("stall_data_lit", 1, 64'(out_data[63:32]), 64'd301);
        in_valid[1] = 1'b0;
        in_stall[1] = 1'b0;
        tick();
        chk("drain_data_lit", 1, 64'(out_data[63:32]), 64'd304);
        chk("drain_occ_lit", 1, 64'(occupancy[5:3]), 64'd3);
        for (int c = 0; c < 5; c++) tick();

        // Channel 2 holds 3 entries, then a single-cycle flush
        in_stall[2] = 1'b1;
        in_valid[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data[2*DATA_W +: DATA_W] = 32'(200 + c);
            tick();
        end
        chk("fill_occ_lit", 2, 64'(occupancy[8:6]), 64'd3);
        in_valid[2] = 1'b0;
        in_flush[2] = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0*DATA_W +: DATA_W] = 32'd9;
        tick();
        chk("flush_occ_lit", 2, 64'(occupancy[8:6]), 64'd0);
        chk("flush_valid_lit", 2, 64'(out_valid[2]), 64'd0);
        chk("flush_out_lit", 2, 64'(out_flush[2]), 64'd1);
        chk("flush_other_lit", 0, 64'(out_valid[0]), 64'd1);
        in_flush[2] = 1'b0;
        in_valid[0] = 1'b0;
        tick();
        chk("flush_end_lit", 2, 64'(out_flush[2]), 64'd0);
        in_stall = '0;

        // All channels valid every cycle, no stall
        in_valid = '1;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < NUM_CH; i++)
                in_data[i*DATA_W +: DATA_W] = 32'((i << 8) + c);
            tick();
        end
        in_valid = '0;
        for (int c = 0; c < 20; c++) tick();

        // Randomized traffic with upstream that holds words until accepted
        for (int i = 0; i < NUM_CH; i++) begin
            src_v[i] = 1'b0;
            src_d[i] = '0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!src_v[i] || m_acc[i] || in_flush[i]) begin
                    src_v[i] = ($urandom % 10) < 8;
                    src_d[i] = $urandom;
                end
                in_valid[i] = src_v[i];
                in_data[i*DATA_W +: DATA_W] = src_d[i];
                in_stall[i] = ($urandom % 10) < 4;
                in_flush[i] = ($urandom % 40) == 0;
            end
            tick();
            if (c == 400) begin
                #2 reset = 1'b0;
                model_reset();
                #1;
                compare();
                chk("async_reset_lit", 0, 64'(occupancy), 64'd0);
                #2 reset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
